// File: rtl/el2_ifu_ic_miss_fill.sv
// el2_ifu_ic_miss_fill
// -----------------------------------------------------------------------------
// Instruction-cache miss fill engine. When the fetch unit reports a miss, this
// block issues one AXI INCR read burst for the whole cache line and writes
// each returned 64-bit beat into the selected way of the I-cache data array.
// Only one read is ever outstanding.
//
// A flush abandons the fill. The block still finishes the AXI transaction, so
// the bus protocol stays legal: an AR that is already being offered is not
// withdrawn, and every remaining R beat is accepted without being written.
// An error response on any beat stops all further writes for that line. The
// done pulse then reports the error.
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   io_miss_req/addr/way         miss request, fetch address [31:1], one-hot way
//   io_flush                     abandon the current fill
//   io_ifu_axi_ar*               AR channel (line-aligned INCR burst)
//   io_ifu_axi_r*                R channel (rid is not checked)
//   io_ic_wr_en/addr/data        data-array write port, one cycle after each beat
//   io_miss_busy                 engine is not idle
//   io_fill_done/io_fill_err     end-of-fill pulse and its error qualifier
//   io_ifu_pmu_bus_trxn/busy     PMU event strobes
// -----------------------------------------------------------------------------
module el2_ifu_ic_miss_fill #(
  parameter int LINE_BEATS = 8,
  parameter int WAYS       = 2,
  parameter int AXI_ID     = 0
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            io_miss_req,
  input  logic [30:0]     io_miss_addr,
  input  logic [WAYS-1:0] io_miss_way,
  input  logic            io_flush,

  output logic            io_ifu_axi_arvalid,
  input  logic            io_ifu_axi_arready,
  output logic [31:0]     io_ifu_axi_araddr,
  output logic [2:0]      io_ifu_axi_arid,
  output logic [7:0]      io_ifu_axi_arlen,
  output logic [2:0]      io_ifu_axi_arsize,
  output logic [1:0]      io_ifu_axi_arburst,

  input  logic            io_ifu_axi_rvalid,
  output logic            io_ifu_axi_rready,
  input  logic [63:0]     io_ifu_axi_rdata,
  input  logic [1:0]      io_ifu_axi_rresp,

  output logic [WAYS-1:0] io_ic_wr_en,
  output logic [30:0]     io_ic_wr_addr,
  output logic [63:0]     io_ic_wr_data,

  output logic            io_miss_busy,
  output logic            io_fill_done,
  output logic            io_fill_err,
  output logic            io_ifu_pmu_bus_trxn,
  output logic            io_ifu_pmu_bus_busy
);

  localparam int CW = $clog2(LINE_BEATS);
  // Mask of the in-line offset bits. The mask is in [31:1] units, so a line of
  // LINE_BEATS*8 bytes spans LINE_BEATS*4 halfwords.
  localparam logic [30:0] LINE_MASK = 31'(LINE_BEATS * 4 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [30:0]     line_q, line_d;
  logic [WAYS-1:0] way_q, way_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            abandon_q, abandon_d;
  logic [WAYS-1:0] wr_en_q, wr_en_d;
  logic [30:0]     wr_addr_q, wr_addr_d;
  logic [63:0]     wr_data_q, wr_data_d;
  logic            done_q, done_d;
  logic            done_err_q, done_err_d;

  logic            arvalid;
  logic            rready;
  logic            ar_hs;
  logic            r_hs;
  logic            last_beat;
  logic            beat_bad;

  // Next-state and datapath logic. The write port is registered, so each beat
  // is written one cycle after it is accepted. The done pulse shares that
  // register stage, which lines it up with the final write.
  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    way_d      = way_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    abandon_d  = abandon_q;
    wr_en_d    = '0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    done_d     = 1'b0;
    done_err_d = 1'b0;

    arvalid   = (state_q == ADDR);
    rready    = (state_q == DATA) || (state_q == DRAIN);
    ar_hs     = arvalid & io_ifu_axi_arready;
    r_hs      = rready & io_ifu_axi_rvalid;
    last_beat = (cnt_q == CW'(LINE_BEATS - 1));
    beat_bad  = (io_ifu_axi_rresp != 2'b00);

    unique case (state_q)
      IDLE: begin
        if (io_miss_req && !io_flush) begin
          state_d   = ADDR;
          line_d    = io_miss_addr & ~LINE_MASK;
          way_d     = io_miss_way;
          cnt_d     = '0;
          err_d     = 1'b0;
          abandon_d = 1'b0;
        end
      end

      ADDR: begin
        // arvalid must stay up once it is offered. A flush here only records
        // that the data must be thrown away.
        if (io_flush) begin
          abandon_d = 1'b1;
        end
        if (ar_hs) begin
          cnt_d   = '0;
          state_d = (abandon_q || io_flush) ? DRAIN : DATA;
        end
      end

      DATA: begin
        if (r_hs) begin
          cnt_d = cnt_q + CW'(1);
          if (beat_bad) begin
            err_d = 1'b1;
          end
          if (!io_flush && !beat_bad && !err_q) begin
            wr_en_d   = way_q;
            wr_addr_d = line_q + (31'(cnt_q) << 2);
            wr_data_d = io_ifu_axi_rdata;
          end
          // When a flush arrives on the last beat, the burst is already
          // complete. Return to IDLE, but do not report the fill as done.
          if (last_beat) begin
            state_d = IDLE;
            if (!io_flush) begin
              done_d     = 1'b1;
              done_err_d = err_q | beat_bad;
            end
          end else if (io_flush) begin
            state_d = DRAIN;
          end
        end else if (io_flush) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (r_hs) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset discards any fill in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      line_q     <= '0;
      way_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      abandon_q  <= 1'b0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      way_q      <= way_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      abandon_q  <= abandon_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  // All outputs are forced low while reset is asserted, so nothing reaches the
  // bus or the array in the cycle before the registers clear. The AR attribute
  // fields are driven only while arvalid is high.
  assign io_ifu_axi_arvalid  = arvalid & ~reset;
  assign io_ifu_axi_araddr   = io_ifu_axi_arvalid ? {line_q, 1'b0} : '0;
  assign io_ifu_axi_arid     = io_ifu_axi_arvalid ? 3'(AXI_ID) : '0;
  assign io_ifu_axi_arlen    = io_ifu_axi_arvalid ? 8'(LINE_BEATS - 1) : '0;
  assign io_ifu_axi_arsize   = io_ifu_axi_arvalid ? 3'd3 : '0;
  assign io_ifu_axi_arburst  = io_ifu_axi_arvalid ? 2'b01 : '0;
  assign io_ifu_axi_rready   = rready & ~reset;

  assign io_ic_wr_en         = reset ? '0 : wr_en_q;
  assign io_ic_wr_addr       = reset ? '0 : wr_addr_q;
  assign io_ic_wr_data       = reset ? '0 : wr_data_q;

  assign io_miss_busy        = (state_q != IDLE) & ~reset;
  assign io_fill_done        = done_q & ~reset;
  assign io_fill_err         = done_err_q & ~reset;
  assign io_ifu_pmu_bus_trxn = io_ifu_axi_arvalid & io_ifu_axi_arready;
  assign io_ifu_pmu_bus_busy = io_ifu_axi_arvalid & ~io_ifu_axi_arready;

endmodule

// File: tb/tb_el2_ifu_ic_miss_fill.sv
// tb_el2_ifu_ic_miss_fill
// -----------------------------------------------------------------------------
// Directed testbench for el2_ifu_ic_miss_fill with LINE_BEATS=8 and WAYS=2.
// Inputs change on the falling clock edge. A monitor samples 4 ns later, just
// before the rising edge, and logs array writes, done pulses, AR handshakes
// and R handshakes. Each test task drives its own scenario and checks the log
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_el2_ifu_ic_miss_fill;

  localparam int LINE_BEATS = 8;
  localparam int WAYS       = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_miss_req;
  logic [30:0]     io_miss_addr;
  logic [WAYS-1:0] io_miss_way;
  logic            io_flush;
  logic            io_ifu_axi_arvalid;
  logic            io_ifu_axi_arready;
  logic [31:0]     io_ifu_axi_araddr;
  logic [2:0]      io_ifu_axi_arid;
  logic [7:0]      io_ifu_axi_arlen;
  logic [2:0]      io_ifu_axi_arsize;
  logic [1:0]      io_ifu_axi_arburst;
  logic            io_ifu_axi_rvalid;
  logic            io_ifu_axi_rready;
  logic [63:0]     io_ifu_axi_rdata;
  logic [1:0]      io_ifu_axi_rresp;
  logic [WAYS-1:0] io_ic_wr_en;
  logic [30:0]     io_ic_wr_addr;
  logic [63:0]     io_ic_wr_data;
  logic            io_miss_busy;
  logic            io_fill_done;
  logic            io_fill_err;
  logic            io_ifu_pmu_bus_trxn;
  logic            io_ifu_pmu_bus_busy;

  int checks = 0;
  int passed = 0;

  el2_ifu_ic_miss_fill #(
    .LINE_BEATS(LINE_BEATS),
    .WAYS      (WAYS),
    .AXI_ID    (0)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_miss_req        (io_miss_req),
    .io_miss_addr       (io_miss_addr),
    .io_miss_way        (io_miss_way),
    .io_flush           (io_flush),
    .io_ifu_axi_arvalid (io_ifu_axi_arvalid),
    .io_ifu_axi_arready (io_ifu_axi_arready),
    .io_ifu_axi_araddr  (io_ifu_axi_araddr),
    .io_ifu_axi_arid    (io_ifu_axi_arid),
    .io_ifu_axi_arlen   (io_ifu_axi_arlen),
    .io_ifu_axi_arsize  (io_ifu_axi_arsize),
    .io_ifu_axi_arburst (io_ifu_axi_arburst),
    .io_ifu_axi_rvalid  (io_ifu_axi_rvalid),
    .io_ifu_axi_rready  (io_ifu_axi_rready),
    .io_ifu_axi_rdata   (io_ifu_axi_rdata),
    .io_ifu_axi_rresp   (io_ifu_axi_rresp),
    .io_ic_wr_en        (io_ic_wr_en),
    .io_ic_wr_addr      (io_ic_wr_addr),
    .io_ic_wr_data      (io_ic_wr_data),
    .io_miss_busy       (io_miss_busy),
    .io_fill_done       (io_fill_done),
    .io_fill_err        (io_fill_err),
    .io_ifu_pmu_bus_trxn(io_ifu_pmu_bus_trxn),
    .io_ifu_pmu_bus_busy(io_ifu_pmu_bus_busy)
  );

  always #5 clock = ~clock;

  // Monitor log
  int              cyc = 0;
  logic [WAYS-1:0] wen_log[$];
  logic [30:0]     wa_log[$];
  logic [63:0]     wd_log[$];
  int              ar_cycles[$];
  int              r_cycles[$];
  int              done_count;
  int              done_pos;
  logic            done_err;
  bit              busy_hist [0:8191];

  always begin
    @(negedge clock);
    #4;
    cyc++;
    if (|io_ic_wr_en) begin
      wen_log.push_back(io_ic_wr_en);
      wa_log.push_back(io_ic_wr_addr);
      wd_log.push_back(io_ic_wr_data);
    end
    if (io_fill_done) begin
      done_count++;
      done_err = io_fill_err;
      done_pos = wen_log.size();
    end
    if (io_ifu_pmu_bus_trxn) ar_cycles.push_back(cyc);
    if (io_ifu_axi_rvalid && io_ifu_axi_rready) r_cycles.push_back(cyc);
    if (cyc < 8192) busy_hist[cyc] = io_miss_busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] beat_data(input int seed, input int i);
    return {16'hBEEF, 16'(seed), 24'h0, 8'(i)};
  endfunction

  task automatic clear_log();
    wen_log.delete();
    wa_log.delete();
    wd_log.delete();
    ar_cycles.delete();
    r_cycles.delete();
    done_count = 0;
    done_pos   = -1;
    done_err   = 1'b0;
  endtask

  task automatic start_miss(input logic [30:0] a, input logic [WAYS-1:0] w);
    @(negedge clock);
    io_miss_req  = 1'b1;
    io_miss_addr = a;
    io_miss_way  = w;
  endtask

  // Called at a falling edge with the DUT in ADDR. arready is held low for
  // hold_low cycles, and a flush is pulsed on stall cycle flush_at. The task
  // returns the number of stall cycles in which arvalid, pmu_bus_busy and the
  // expected araddr were all present.
  task automatic do_ar(input int hold_low, input int flush_at,
                       input logic [31:0] exp_araddr, output int arv_high);
    arv_high = 0;
    for (int c = 0; c < hold_low; c++) begin
      io_ifu_axi_arready = 1'b0;
      io_flush           = (c == flush_at);
      #1;
      if (io_ifu_axi_arvalid && io_ifu_pmu_bus_busy &&
          io_ifu_axi_araddr === exp_araddr) arv_high++;
      @(negedge clock);
    end
    io_flush           = 1'b0;
    io_ifu_axi_arready = 1'b1;
    @(negedge clock);
    io_ifu_axi_arready = 1'b0;
  endtask

  // Sends n beats on R. Beat bad_idx gets SLVERR, and io_flush is pulsed with
  // beat flush_idx. When gapped is set, an idle cycle precedes every beat.
  task automatic send_beats(input int seed, input int n, input int bad_idx,
                            input int flush_idx, input bit gapped);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        @(negedge clock);
        io_ifu_axi_rvalid = 1'b0;
        io_flush          = 1'b0;
      end
      @(negedge clock);
      io_ifu_axi_rvalid = 1'b0;
      io_flush          = 1'b0;
      w = 0;
      while (io_ifu_axi_rready !== 1'b1 && w < 20) begin
        @(negedge clock);
        w++;
      end
      if (w >= 20) begin
        checks++;
        $display("[TB] FAIL beat_wait: rready stayed %b, required 1 (beat %0d)",
                 io_ifu_axi_rready, i);
        return;
      end
      io_ifu_axi_rvalid = 1'b1;
      io_ifu_axi_rdata  = beat_data(seed, i);
      io_ifu_axi_rresp  = (i == bad_idx) ? 2'b10 : 2'b00;
      io_flush          = (i == flush_idx);
    end
    @(negedge clock);
    io_ifu_axi_rvalid = 1'b0;
    io_ifu_axi_rresp  = 2'b00;
    io_flush          = 1'b0;
  endtask

  task automatic test_reset();
    reset              = 1'b1;
    io_miss_req        = 1'b1;
    io_miss_addr       = 31'h24;
    io_miss_way        = 2'b10;
    io_ifu_axi_arready = 1'b1;
    io_ifu_axi_rvalid  = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({io_miss_busy, io_ifu_axi_arvalid, io_ifu_axi_rready, io_ic_wr_en,
         io_fill_done, io_fill_err, io_ifu_pmu_bus_trxn, io_ifu_pmu_bus_busy} !== 9'b0)
      $display("[TB] FAIL reset_during: ctrl outputs got %b required 0",
               {io_miss_busy, io_ifu_axi_arvalid, io_ifu_axi_rready, io_ic_wr_en,
                io_fill_done, io_fill_err, io_ifu_pmu_bus_trxn, io_ifu_pmu_bus_busy});
    else passed++;
    reset              = 1'b0;
    io_miss_req        = 1'b0;
    io_ifu_axi_arready = 1'b0;
    io_ifu_axi_rvalid  = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_miss_busy, io_ifu_axi_arvalid, io_ifu_axi_rready, io_ic_wr_en,
         io_fill_done, io_fill_err, io_ifu_pmu_bus_trxn, io_ifu_pmu_bus_busy} !== 9'b0)
      $display("[TB] FAIL reset_after_ctrl: got %b required 0",
               {io_miss_busy, io_ifu_axi_arvalid, io_ifu_axi_rready, io_ic_wr_en,
                io_fill_done, io_fill_err, io_ifu_pmu_bus_trxn, io_ifu_pmu_bus_busy});
    else passed++;
    checks++;
    if ({io_ifu_axi_araddr, io_ifu_axi_arlen, io_ic_wr_addr, io_ic_wr_data} !== '0)
      $display("[TB] FAIL reset_after_data: araddr %h wr_addr %h wr_data %h required 0",
               io_ifu_axi_araddr, io_ic_wr_addr, io_ic_wr_data);
    else passed++;
  endtask

  task automatic test_basic_fill();
    int arv;
    clear_log();
    start_miss(31'h0000_0024, 2'b10);
    @(negedge clock);
    io_miss_req = 1'b0;
    checks++;
    if (io_ifu_axi_arvalid !== 1'b1 || io_ifu_axi_araddr !== 32'h0000_0040)
      $display("[TB] FAIL basic_ar: arvalid %b araddr %h required 1 / 00000040",
               io_ifu_axi_arvalid, io_ifu_axi_araddr);
    else passed++;
    checks++;
    if ({io_ifu_axi_arlen, io_ifu_axi_arsize, io_ifu_axi_arburst, io_ifu_axi_arid} !==
        {8'd7, 3'd3, 2'b01, 3'd0})
      $display("[TB] FAIL basic_attr: len %0d size %0d burst %b id %0d required 7/3/01/0",
               io_ifu_axi_arlen, io_ifu_axi_arsize, io_ifu_axi_arburst, io_ifu_axi_arid);
    else passed++;
    do_ar(0, -1, 32'h40, arv);
    send_beats(1, LINE_BEATS, -1, -1, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if (wen_log.size() != 8)
      $display("[TB] FAIL basic_wr_count: got %0d required 8", wen_log.size());
    else passed++;
    for (int i = 0; i < 8; i++) begin
      if (i < wen_log.size()) begin
        checks++;
        if ({wen_log[i], wa_log[i], wd_log[i]} !== {2'b10, 31'(32'h20 + 4 * i), beat_data(1, i)})
          $display("[TB] FAIL basic_wr[%0d]: en %b addr %h data %h required 10 %h %h",
                   i, wen_log[i], wa_log[i], wd_log[i], 31'(32'h20 + 4 * i), beat_data(1, i));
        else passed++;
      end
    end
    checks++;
    if (done_count != 1 || done_pos != 8 || done_err !== 1'b0)
      $display("[TB] FAIL basic_done: count %0d at write %0d err %b required 1 / 8 / 0",
               done_count, done_pos, done_err);
    else passed++;
    checks++;
    if (ar_cycles.size() != 1 || io_miss_busy !== 1'b0)
      $display("[TB] FAIL basic_end: ar count %0d busy %b required 1 / 0",
               ar_cycles.size(), io_miss_busy);
    else passed++;
  endtask

  task automatic test_ar_flush();
    int arv;
    clear_log();
    start_miss(31'h0000_0024, 2'b01);
    @(negedge clock);
    io_miss_req = 1'b0;
    do_ar(5, 2, 32'h40, arv);
    checks++;
    if (arv != 5)
      $display("[TB] FAIL arflush_arvalid: held cycles %0d required 5", arv);
    else passed++;
    send_beats(2, LINE_BEATS, -1, -1, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if (wen_log.size() != 0 || done_count != 0)
      $display("[TB] FAIL arflush_no_write: writes %0d done %0d required 0 / 0",
               wen_log.size(), done_count);
    else passed++;
    checks++;
    if (r_cycles.size() != 8 || io_miss_busy !== 1'b0)
      $display("[TB] FAIL arflush_drain: beats %0d busy %b required 8 / 0",
               r_cycles.size(), io_miss_busy);
    else passed++;
  endtask

  task automatic test_beat_error();
    int arv;
    clear_log();
    start_miss(31'h0000_1234, 2'b01);
    @(negedge clock);
    io_miss_req = 1'b0;
    checks++;
    if (io_ifu_axi_araddr !== 32'h0000_2440)
      $display("[TB] FAIL err_araddr: got %h required 00002440", io_ifu_axi_araddr);
    else passed++;
    do_ar(0, -1, 32'h2440, arv);
    send_beats(3, LINE_BEATS, 3, -1, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if (wen_log.size() != 3)
      $display("[TB] FAIL err_wr_count: got %0d required 3", wen_log.size());
    else passed++;
    if (wen_log.size() == 3) begin
      checks++;
      if ({wen_log[2], wa_log[2], wd_log[2]} !== {2'b01, 31'h1228, beat_data(3, 2)})
        $display("[TB] FAIL err_wr2: en %b addr %h data %h required 01 1228 %h",
                 wen_log[2], wa_log[2], wd_log[2], beat_data(3, 2));
      else passed++;
    end
    checks++;
    if (done_count != 1 || done_err !== 1'b1 || done_pos != 3)
      $display("[TB] FAIL err_done: count %0d err %b pos %0d required 1 / 1 / 3",
               done_count, done_err, done_pos);
    else passed++;
  endtask

  task automatic test_data_flush();
    int arv;
    clear_log();
    start_miss(31'h7FFF_FFFF, 2'b10);
    @(negedge clock);
    io_miss_req = 1'b0;
    checks++;
    if (io_ifu_axi_araddr !== 32'hFFFF_FFC0)
      $display("[TB] FAIL dflush_araddr: got %h required ffffffc0", io_ifu_axi_araddr);
    else passed++;
    do_ar(0, -1, 32'hFFFF_FFC0, arv);
    send_beats(4, LINE_BEATS, -1, 4, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if (wen_log.size() != 4)
      $display("[TB] FAIL dflush_wr_count: got %0d required 4", wen_log.size());
    else passed++;
    if (wen_log.size() == 4) begin
      checks++;
      if ({wen_log[3], wa_log[3], wd_log[3]} !== {2'b10, 31'h7FFF_FFEC, beat_data(4, 3)})
        $display("[TB] FAIL dflush_wr3: en %b addr %h data %h required 10 7fffffec %h",
                 wen_log[3], wa_log[3], wd_log[3], beat_data(4, 3));
      else passed++;
    end
    checks++;
    if (done_count != 0 || r_cycles.size() != 8 || io_miss_busy !== 1'b0)
      $display("[TB] FAIL dflush_end: done %0d beats %0d busy %b required 0 / 8 / 0",
               done_count, r_cycles.size(), io_miss_busy);
    else passed++;
  endtask

  task automatic test_reset_mid_data();
    int arv;
    clear_log();
    start_miss(31'h0000_0088, 2'b01);
    @(negedge clock);
    io_miss_req = 1'b0;
    do_ar(0, -1, 32'h100, arv);
    send_beats(5, 3, -1, -1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({io_miss_busy, io_ifu_axi_rready, io_ic_wr_en} !== 4'b0)
      $display("[TB] FAIL rstmid_during: busy %b rready %b wr_en %b required 0",
               io_miss_busy, io_ifu_axi_rready, io_ic_wr_en);
    else passed++;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_miss_busy, io_ifu_axi_rready, io_ic_wr_en, io_fill_done} !== 5'b0)
      $display("[TB] FAIL rstmid_after: busy %b rready %b wr_en %b done %b required 0",
               io_miss_busy, io_ifu_axi_rready, io_ic_wr_en, io_fill_done);
    else passed++;
    checks++;
    if (wen_log.size() != 3 || done_count != 0)
      $display("[TB] FAIL rstmid_partial: writes %0d done %0d required 3 / 0",
               wen_log.size(), done_count);
    else passed++;
    clear_log();
    start_miss(31'h0000_0100, 2'b01);
    @(negedge clock);
    io_miss_req = 1'b0;
    checks++;
    if (io_ifu_axi_arvalid !== 1'b1 || io_ifu_axi_araddr !== 32'h0000_0200)
      $display("[TB] FAIL rstmid_new_ar: arvalid %b araddr %h required 1 / 00000200",
               io_ifu_axi_arvalid, io_ifu_axi_araddr);
    else passed++;
    do_ar(0, -1, 32'h200, arv);
    send_beats(6, LINE_BEATS, -1, -1, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if (wen_log.size() != 8 || done_count != 1 || done_err !== 1'b0)
      $display("[TB] FAIL rstmid_clean: writes %0d done %0d err %b required 8 / 1 / 0",
               wen_log.size(), done_count, done_err);
    else passed++;
    if (wen_log.size() == 8) begin
      checks++;
      if ({wen_log[0], wa_log[0], wa_log[7]} !== {2'b01, 31'h100, 31'h11C})
        $display("[TB] FAIL rstmid_addr: en %b first %h last %h required 01 100 11c",
                 wen_log[0], wa_log[0], wa_log[7]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    @(negedge clock);
    io_miss_req        = 1'b1;
    io_miss_addr       = 31'h0000_0040;
    io_miss_way        = 2'b01;
    io_ifu_axi_arready = 1'b1;
    send_beats(7, LINE_BEATS, -1, -1, 1'b1);
    repeat (3) @(negedge clock);
    io_miss_req        = 1'b0;
    io_ifu_axi_arready = 1'b0;
    send_beats(8, LINE_BEATS, -1, -1, 1'b0);
    repeat (3) @(negedge clock);
    checks++;
    if (ar_cycles.size() != 2 || r_cycles.size() != 16)
      $display("[TB] FAIL b2b_counts: ARs %0d beats %0d required 2 / 16",
               ar_cycles.size(), r_cycles.size());
    else passed++;
    if (ar_cycles.size() == 2 && r_cycles.size() == 16) begin
      checks++;
      if (ar_cycles[1] != r_cycles[7] + 2)
        $display("[TB] FAIL b2b_ar_timing: second AR at cycle %0d required %0d",
                 ar_cycles[1], r_cycles[7] + 2);
      else passed++;
      checks++;
      if (busy_hist[r_cycles[7] + 1] !== 1'b0)
        $display("[TB] FAIL b2b_idle_gap: busy %b required 0", busy_hist[r_cycles[7] + 1]);
      else passed++;
    end
    checks++;
    if (wen_log.size() != 16 || done_count != 2)
      $display("[TB] FAIL b2b_writes: writes %0d done %0d required 16 / 2",
               wen_log.size(), done_count);
    else passed++;
    if (wen_log.size() == 16) begin
      checks++;
      if ({wa_log[7], wd_log[7]} !== {31'h5C, beat_data(7, 7)})
        $display("[TB] FAIL b2b_wr7: addr %h data %h required 5c %h",
                 wa_log[7], wd_log[7], beat_data(7, 7));
      else passed++;
    end
  endtask

  initial begin
    reset              = 1'b1;
    io_miss_req        = 1'b0;
    io_miss_addr       = '0;
    io_miss_way        = '0;
    io_flush           = 1'b0;
    io_ifu_axi_arready = 1'b0;
    io_ifu_axi_rvalid  = 1'b0;
    io_ifu_axi_rdata   = '0;
    io_ifu_axi_rresp   = 2'b00;
    clear_log();
    test_reset();
    test_basic_fill();
    test_ar_flush();
    test_beat_error();
    test_data_flush();
    test_reset_mid_data();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
